// File: rtl/vx_dcr_noc_decoder_if.sv
// rtl/vx_dcr_noc_decoder_if.sv - NoC flit ports and DCR-buffer write port of the DCR NoC decoder
interface vx_dcr_noc_decoder_if #(
  parameter int VX_DCR_ADDR_WIDTH = 8,
  parameter int VX_DCR_DATA_WIDTH = 32
);
  logic                         noc_in_val;
  logic [63:0]                  noc_in_data;
  logic                         noc_in_rdy;
  logic                         noc_out_val;
  logic [63:0]                  noc_out_data;
  logic                         noc_out_rdy;
  logic                         dcr_buffer_wr_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] dcr_buffer_wr_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] dcr_buffer_wr_data;
  logic                         vx_buffer_rdy;
  logic [7:0]                   err_count;

  // decoder side
  modport slave (
    input  noc_in_val, noc_in_data, noc_out_rdy, vx_buffer_rdy,
    output noc_in_rdy, noc_out_val, noc_out_data,
    output dcr_buffer_wr_valid, dcr_buffer_wr_addr, dcr_buffer_wr_data, err_count
  );

  // NoC crossbar / DCR buffer side
  modport master (
    output noc_in_val, noc_in_data, noc_out_rdy, vx_buffer_rdy,
    input  noc_in_rdy, noc_out_val, noc_out_data,
    input  dcr_buffer_wr_valid, dcr_buffer_wr_addr, dcr_buffer_wr_data, err_count
  );
endinterface

// File: rtl/vx_dcr_noc_decoder.sv
// rtl/vx_dcr_noc_decoder.sv - Piton NoC DCR-write decoder feeding the Vortex DCR buffer; optional VX_DCR_ADDR_CHECK_EN
module vx_dcr_noc_decoder #(
  parameter int                         VX_DCR_ADDR_WIDTH = 8,
  parameter int                         VX_DCR_DATA_WIDTH = 32,
  parameter logic [7:0]                 MSG_TYPE_ACK      = 8'd23,
  parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_ADDR_MIN    = 8'h00,
  parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_ADDR_MAX    = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vx_dcr_noc_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_DATA, S_DRAIN, S_ISSUE, S_ACK
  } state_t;

  state_t                       state_q, state_d;
  logic [33:0]                  route_q;
  logic [7:0]                   mshr_q;
  logic [7:0]                   cnt_q, cnt_d;
  logic [VX_DCR_ADDR_WIDTH-1:0] addr_q;
  logic [VX_DCR_DATA_WIDTH-1:0] data_q;
  logic [7:0]                   err_q;
  logic                         in_rdy;
  logic                         in_fire;
  logic [7:0]                   hdr_len;
  logic                         err_inc;
  logic                         hdr_take;
  logic                         addr_take;
  logic                         data_take;

  // an empty legal-address window is a configuration mistake
  if (DCR_ADDR_MIN > DCR_ADDR_MAX) begin : g_bad_range
    $error("vx_dcr_noc_decoder: DCR_ADDR_MIN exceeds DCR_ADDR_MAX");
  end

  // inbound is open only while a message is being collected; all outputs decode registers
  assign in_rdy  = (state_q == S_HDR) || (state_q == S_ADDR) ||
                   (state_q == S_DATA) || (state_q == S_DRAIN);
  assign in_fire = bus.noc_in_val && in_rdy;
  assign hdr_len = bus.noc_in_data[29:22];

  assign bus.noc_in_rdy          = in_rdy;
  assign bus.noc_out_val         = (state_q == S_ACK);
  assign bus.noc_out_data        = (state_q == S_ACK) ?
                                   {route_q, 8'd0, MSG_TYPE_ACK, mshr_q, 6'd0} : 64'd0;
  assign bus.dcr_buffer_wr_valid = (state_q == S_ISSUE);
  assign bus.dcr_buffer_wr_addr  = addr_q;
  assign bus.dcr_buffer_wr_data  = data_q;
  assign bus.err_count           = err_q;

  // state register and per-message latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR;
      route_q <= '0;
      mshr_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hdr_take) begin
        route_q <= bus.noc_in_data[63:30];
        mshr_q  <= bus.noc_in_data[13:6];
      end
      if (addr_take) addr_q <= bus.noc_in_data[VX_DCR_ADDR_WIDTH-1:0];
      if (data_take) data_q <= bus.noc_in_data[VX_DCR_DATA_WIDTH-1:0];
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  // message decode: one header, then addr/data or a drain of the payload, then a single ack
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_inc   = 1'b0;
    hdr_take  = 1'b0;
    addr_take = 1'b0;
    data_take = 1'b0;
    case (state_q)
      S_HDR: begin
        if (in_fire) begin
          hdr_take = 1'b1;
          if (hdr_len == 8'd2) begin
            state_d = S_ADDR;
          end else if (hdr_len == 8'd0) begin
            state_d = S_ACK;
            err_inc = 1'b1;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = hdr_len;
            err_inc = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (in_fire) begin
          addr_take = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (in_fire) begin
          data_take = 1'b1;
`ifdef VX_DCR_ADDR_CHECK_EN
          if ((addr_q < DCR_ADDR_MIN) || (addr_q > DCR_ADDR_MAX)) begin
            state_d = S_ACK;
            err_inc = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_DRAIN: begin
        if (in_fire) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_ACK;
        end
      end
      S_ISSUE: begin
        if (bus.vx_buffer_rdy) state_d = S_ACK;
      end
      S_ACK: begin
        if (bus.noc_out_rdy) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

endmodule
